// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the CPU memory arbiter
package mem_arb_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  typedef logic [1:0] byte_en_t;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// rtl/mem_arb_starve_ctr.sv - saturating fetch-denial counter; o_sat high once MAX denials are counted
module mem_arb_starve_ctr #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);

  localparam int CW = $clog2(MAX + 1);
  localparam logic [CW-1:0] MAX_V = CW'(MAX);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAX_V)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_sat = (r_cnt == MAX_V);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for the shared 16-bit memory
// Optional ROUND_ROBIN_EN: alternating priority instead of data priority with starvation guard.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_DEPTH  = 8192,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  d_req,
  input  byte_en_t              d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  mem_en,
  output logic                  mem_rd_en,
  output byte_en_t              mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_din,
  input  logic [DATA_W-1:0]     mem_dout
);

  owner_t r_owner;
  logic   w_if_pick;
  logic   w_d_read;

`ifdef ROUND_ROBIN_EN
  logic r_last_d;

  // On contention the requester that did not win last time goes first.
  assign w_if_pick = if_req && (!d_req || r_last_d);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_d <= 1'b1;
    end else if (if_gnt) begin
      r_last_d <= 1'b0;
    end else if (d_gnt) begin
      r_last_d <= 1'b1;
    end
  end
`else
  logic w_starved;

  mem_arb_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk   (clk),
    .rst   (rst),
    .i_inc (if_req && !if_gnt),
    .i_clr (if_gnt || !if_req),
    .o_sat (w_starved)
  );

  assign w_if_pick = if_req && (!d_req || w_starved);
`endif

  assign if_gnt   = w_if_pick;
  assign d_gnt    = d_req && !w_if_pick;
  assign w_d_read = d_gnt && (d_we == 2'b00);

  always_comb begin
    mem_en    = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 2'b00;
    mem_addr  = '0;
    mem_din   = '0;
    if (if_gnt) begin
      mem_en    = 1'b1;
      mem_rd_en = 1'b1;
      mem_addr  = if_addr;
    end else if (d_gnt) begin
      mem_en    = 1'b1;
      mem_rd_en = (d_we == 2'b00);
      mem_wr_en = d_we;
      mem_addr  = d_addr;
      mem_din   = d_wdata;
    end
  end

  // Owner marks whose read data appears on mem_dout in the next cycle; writes return nothing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner <= OWN_NONE;
    end else if (if_gnt) begin
      r_owner <= OWN_IF;
    end else if (w_d_read) begin
      r_owner <= OWN_D;
    end else begin
      r_owner <= OWN_NONE;
    end
  end

  assign if_rvalid = (r_owner == OWN_IF);
  assign d_rvalid  = (r_owner == OWN_D);
  assign if_rdata  = mem_dout;
  assign d_rdata   = mem_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter (either ROUND_ROBIN_EN setting)
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid;
  logic [15:0]   if_rdata;
  logic          d_req = 1'b0;
  logic [1:0]    d_we = 2'b00;
  logic [AW-1:0] d_addr = '0;
  logic [15:0]   d_wdata = '0;
  logic          d_gnt, d_rvalid;
  logic [15:0]   d_rdata;
  logic          mem_en, mem_rd_en;
  logic [1:0]    mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_din;
  logic [15:0]   mem_dout = '0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .MEM_DEPTH  (8192),
    .STARVE_MAX (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_rd_en (mem_rd_en),
    .mem_wr_en (mem_wr_en),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  // Byte-addressed memory, 16-bit words, one-cycle read latency.
  logic [15:0] mem [0:4095];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wr_en[0]) mem[mem_addr[AW-1:1]][7:0]  <= mem_din[7:0];
      if (mem_wr_en[1]) mem[mem_addr[AW-1:1]][15:8] <= mem_din[15:8];
      if (mem_rd_en)    mem_dout <= mem[mem_addr[AW-1:1]];
    end
  end

  typedef struct {
    bit          is_if;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input bit is_if, input logic [15:0] data);
    exp_t e;
    e.is_if = is_if;
    e.data  = data;
    sb.push_back(e);
  endtask

  task automatic drive(input bit ireq, input logic [AW-1:0] ia, input bit dreq,
                       input logic [1:0] dwe, input logic [AW-1:0] da, input logic [15:0] dw);
    @(posedge clk);
    #1;
    if_req  = ireq;
    if_addr = ia;
    d_req   = dreq;
    d_we    = dwe;
    d_addr  = da;
    d_wdata = dw;
    #1;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && (if_rvalid || d_rvalid)) begin
      checks++;
      if (if_rvalid && d_rvalid) begin
        errors++;
        $display("FAIL rvalid_both: got if=1 d=1 expected one");
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL rvalid_unexpected: got if=%0b d=%0b expected none", if_rvalid, d_rvalid);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.is_if != if_rvalid) begin
          errors++;
          $display("FAIL rvalid_port: got if_rvalid=%0b expected %0b", if_rvalid, mon_e.is_if);
        end else if ((if_rvalid ? if_rdata : d_rdata) !== mon_e.data) begin
          errors++;
          $display("FAIL rdata: got %0h expected %0h", if_rvalid ? if_rdata : d_rdata, mon_e.data);
        end
      end
    end
  end

`ifdef ROUND_ROBIN_EN
  localparam string PATTERN = "IDIDIDID";
`else
  localparam string PATTERN = "DDDDIDDD";
`endif

  initial begin
    string pat;
    pat = PATTERN;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    mem[13'h0010 >> 1] = 16'hBEEF;
    mem[13'h0002 >> 1] = 16'hA5A5;
    mem[13'h0004 >> 1] = 16'h5A5A;
    mem[13'h0020 >> 1] = 16'hFF00;

    #12;
    chk("reset_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("reset_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("idle_mem_en", 32'(mem_en), 32'd0);
    chk("idle_mem_addr", 32'(mem_addr), 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Reset while a fetch read is in flight
    drive(1, 13'h0010, 0, 2'b00, '0, '0);
    chk("t1_if_gnt", 32'(if_gnt), 32'd1);
    @(posedge clk); #1 rst = 1'b0; #1;
    chk("t1_if_rvalid_dropped", 32'(if_rvalid), 32'd0);
    chk("t1_d_rvalid_dropped", 32'(d_rvalid), 32'd0);
    chk("t1_gnt_in_reset", 32'(if_gnt), 32'd1);
    drive(0, '0, 0, 2'b00, '0, '0);
    @(posedge clk); #1 rst = 1'b1;

    // Lone fetch
    drive(1, 13'h0010, 0, 2'b00, '0, '0);
    chk("t2_if_gnt", 32'(if_gnt), 32'd1);
    chk("t2_d_gnt", 32'(d_gnt), 32'd0);
    chk("t2_mem_rd_en", 32'(mem_rd_en), 32'd1);
    chk("t2_mem_wr_en", 32'(mem_wr_en), 32'd0);
    chk("t2_mem_addr", 32'(mem_addr), 32'h0010);
    push(1, 16'hBEEF);
    drive(0, '0, 0, 2'b00, '0, '0);
    chk("t2_idle_mem_en", 32'(mem_en), 32'd0);
    chk("t2_idle_mem_din", 32'(mem_din), 32'd0);

    // Low-byte write then readback
    drive(0, '0, 1, 2'b01, 13'h0020, 16'h1234);
    chk("t3_d_gnt", 32'(d_gnt), 32'd1);
    chk("t3_mem_wr_en", 32'(mem_wr_en), 32'd1);
    chk("t3_mem_rd_en", 32'(mem_rd_en), 32'd0);
    chk("t3_mem_din", 32'(mem_din), 32'h1234);
    chk("t3_mem_addr", 32'(mem_addr), 32'h0020);
    drive(0, '0, 0, 2'b00, '0, '0);
    drive(0, '0, 1, 2'b00, 13'h0020, '0);
    chk("t3_rd_gnt", 32'(d_gnt), 32'd1);
    chk("t3_rd_en", 32'(mem_rd_en), 32'd1);
    push(0, 16'hFF34);
    drive(0, '0, 0, 2'b00, '0, '0);

    // Back-to-back data read then fetch
    drive(0, '0, 1, 2'b00, 13'h0002, '0);
    chk("t5_d_gnt", 32'(d_gnt), 32'd1);
    push(0, 16'hA5A5);
    drive(1, 13'h0004, 0, 2'b00, '0, '0);
    chk("t5_if_gnt", 32'(if_gnt), 32'd1);
    chk("t5_mem_addr", 32'(mem_addr), 32'h0004);
    push(1, 16'h5A5A);
    drive(0, '0, 0, 2'b00, '0, '0);

    // Contention from reset
    @(posedge clk); #1 rst = 1'b0; #1 rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1, 13'h0010, 1, 2'b00, 13'h0002, '0);
      chk($sformatf("t4_if_gnt_%0d", i), 32'(if_gnt), 32'(pat[i] == "I"));
      chk($sformatf("t4_d_gnt_%0d", i), 32'(d_gnt), 32'(pat[i] == "D"));
      if (pat[i] == "I") push(1, 16'hBEEF);
      else               push(0, 16'hA5A5);
    end
    drive(0, '0, 0, 2'b00, '0, '0);
    drive(0, '0, 0, 2'b00, '0, '0);
    @(posedge clk); #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
